ad400x_multi_read: RTL and testbench

- Next-generation reader for AD400x-class SAR ADCs in 3-wire CS mode.
- Drives one shared CNV and one shared SCK to NUM_CH converters and captures NUM_CH independent SDO lanes in parallel.
- Width, conversion time and SCK rate are parametrised; supports continuous or single-shot triggering.
- Delivers packed samples through a valid/ready handshake with overrun detection; sits between the ADC pins and the control-board datapath.

---
 rtl/ad400x_multi_read_if.sv | 13 +
 rtl/ad400x_multi_read.sv | 185 ++++++++++++++++++
 tb/tb_ad400x_multi_read.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ad400x_multi_read_if.sv
// Sample stream from the AD400x multi-lane reader to the datapath.
// Channel i occupies data[i*ADC_WIDTH +: ADC_WIDTH]; transfer on data_valid & data_ready.
interface ad400x_multi_read_if #(
  parameter int NUM_CH    = 4,
  parameter int ADC_WIDTH = 16
);
  logic [NUM_CH*ADC_WIDTH-1:0] data;
  logic                        data_valid;
  logic                        data_ready;

  modport master (output data, output data_valid, input data_ready);
  modport slave  (input data, input data_valid, output data_ready);
endinterface

// File: rtl/ad400x_multi_read.sv
// Multi-lane AD400x reader (3-wire CS mode): shared CNV/SCK, NUM_CH parallel SDO captures.
// Define ADC_AVG_EN to publish the truncated mean of 2^AVG_LOG2 conversions instead of each one.
module ad400x_multi_read #(
  parameter int ADC_WIDTH     = 16,
  parameter int NUM_CH        = 4,
  parameter int CONV_CYCLES   = 50,
  parameter int SCK_DIV       = 2,
  parameter int SAMPLE_PERIOD = 100,
  parameter int AVG_LOG2      = 2
) (
  input  logic                clk,
  input  logic                sreset,
  input  logic                continuous,
  input  logic                start,
  input  logic [NUM_CH-1:0]   sdo,
  output logic                cnv,
  output logic                sck,
  output logic                busy,
  output logic                overrun,
  input  logic                overrun_clr,
  ad400x_multi_read_if.master sample
);
  localparam int DATA_W = NUM_CH * ADC_WIDTH;
  localparam int CONV_W = $clog2(CONV_CYCLES + 1);
  localparam int DIV_W  = $clog2(SCK_DIV + 1);
  localparam int BIT_W  = $clog2(ADC_WIDTH + 1);
  localparam int PER_W  = $clog2(SAMPLE_PERIOD + 1);

  if (ADC_WIDTH < 8 || ADC_WIDTH > 24 || NUM_CH < 1 || NUM_CH > 16 ||
      CONV_CYCLES < 2 || SCK_DIV < 1 || AVG_LOG2 < 0) begin : g_bad_params
    $error("ad400x_multi_read: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, CONV, SHIFT, DONE} state_t;

  state_t            state_reg;
  logic [CONV_W-1:0] conv_cnt_reg;
  logic [DIV_W-1:0]  div_cnt_reg;
  logic [BIT_W-1:0]  bit_cnt_reg;
  logic [PER_W-1:0]  period_cnt_reg;
  logic              cnv_reg, sck_reg, busy_reg, valid_reg, overrun_reg;
  logic [DATA_W-1:0] data_reg;
  logic [DATA_W-1:0] publish_data;
  logic              capture_en, publish, handshake;

  // Every lane samples SDO on the clk edge that raises SCK.
  assign capture_en = (state_reg == SHIFT) && (div_cnt_reg == '0) && !sck_reg;
  assign handshake  = valid_reg && sample.data_ready;

`ifdef ADC_AVG_EN
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  logic [CNT_W-1:0] avg_cnt_reg;
  logic             last_conv;

  assign last_conv = (avg_cnt_reg == CNT_W'((1 << AVG_LOG2) - 1));
  assign publish   = (state_reg == DONE) && last_conv;

  always_ff @(posedge clk) begin
    if (sreset) begin
      avg_cnt_reg <= '0;
    end else if (state_reg == DONE) begin
      avg_cnt_reg <= last_conv ? '0 : avg_cnt_reg + 1'b1;
    end
  end
`else
  assign publish = (state_reg == DONE);
`endif

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
    logic [ADC_WIDTH-1:0] shreg_reg;

    always_ff @(posedge clk) begin
      if (sreset) begin
        shreg_reg <= '0;
      end else if (capture_en) begin
        shreg_reg <= {shreg_reg[ADC_WIDTH-2:0], sdo[gi]};
      end
    end

`ifdef ADC_AVG_EN
    localparam int ACC_W = ADC_WIDTH + AVG_LOG2;
    logic [ACC_W-1:0] acc_reg;
    logic [ACC_W-1:0] acc_next;

    assign acc_next = acc_reg + ACC_W'(shreg_reg);

    always_ff @(posedge clk) begin
      if (sreset) begin
        acc_reg <= '0;
      end else if (state_reg == DONE) begin
        acc_reg <= last_conv ? '0 : acc_next;
      end
    end

    assign publish_data[gi*ADC_WIDTH +: ADC_WIDTH] = ADC_WIDTH'(acc_next >> AVG_LOG2);
`else
    assign publish_data[gi*ADC_WIDTH +: ADC_WIDTH] = shreg_reg;
`endif
  end

  always_ff @(posedge clk) begin
    if (sreset) begin
      state_reg      <= IDLE;
      conv_cnt_reg   <= '0;
      div_cnt_reg    <= '0;
      bit_cnt_reg    <= '0;
      period_cnt_reg <= '0;
      cnv_reg        <= 1'b0;
      sck_reg        <= 1'b0;
      busy_reg       <= 1'b0;
      valid_reg      <= 1'b0;
      overrun_reg    <= 1'b0;
      data_reg       <= '0;
    end else begin
      if (period_cnt_reg != '0) begin
        period_cnt_reg <= period_cnt_reg - 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if ((continuous && period_cnt_reg == '0) || (!continuous && start)) begin
            cnv_reg        <= 1'b1;
            busy_reg       <= 1'b1;
            conv_cnt_reg   <= CONV_W'(CONV_CYCLES - 1);
            period_cnt_reg <= PER_W'(SAMPLE_PERIOD - 1);
            state_reg      <= CONV;
          end
        end
        CONV: begin
          if (conv_cnt_reg == '0) begin
            cnv_reg     <= 1'b0;
            div_cnt_reg <= DIV_W'(SCK_DIV - 1);
            bit_cnt_reg <= BIT_W'(ADC_WIDTH - 1);
            state_reg   <= SHIFT;
          end else begin
            conv_cnt_reg <= conv_cnt_reg - 1'b1;
          end
        end
        SHIFT: begin
          if (div_cnt_reg != '0) begin
            div_cnt_reg <= div_cnt_reg - 1'b1;
          end else begin
            div_cnt_reg <= DIV_W'(SCK_DIV - 1);
            if (!sck_reg) begin
              sck_reg <= 1'b1;
            end else begin
              sck_reg <= 1'b0;
              if (bit_cnt_reg == '0) begin
                state_reg <= DONE;
              end else begin
                bit_cnt_reg <= bit_cnt_reg - 1'b1;
              end
            end
          end
        end
        DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase

      // A fresh sample overrides a same-cycle handshake; newest data always wins.
      if (publish) begin
        data_reg  <= publish_data;
        valid_reg <= 1'b1;
      end else if (handshake) begin
        valid_reg <= 1'b0;
      end

      if (publish && valid_reg && !sample.data_ready) begin
        overrun_reg <= 1'b1;
      end else if (overrun_clr) begin
        overrun_reg <= 1'b0;
      end
    end
  end

  assign cnv               = cnv_reg;
  assign sck               = sck_reg;
  assign busy              = busy_reg;
  assign overrun           = overrun_reg;
  assign sample.data       = data_reg;
  assign sample.data_valid = valid_reg;
endmodule

// File: tb/tb_ad400x_multi_read.sv
// Directed bench for ad400x_multi_read: behavioural AD400x SDO emulators, vector table plus
// hand-written continuous, overrun, reset-abort and 18-bit sequences.
module tb_ad400x_multi_read;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       sreset;
  logic       continuous_a, start_a, overrun_clr_a;
  logic [3:0] sdo_a;
  logic       cnv_a, sck_a, busy_a, overrun_a;

  ad400x_multi_read_if #(.NUM_CH(4), .ADC_WIDTH(16)) if_a ();

  ad400x_multi_read #(
    .ADC_WIDTH(16), .NUM_CH(4), .CONV_CYCLES(50), .SCK_DIV(2),
    .SAMPLE_PERIOD(120), .AVG_LOG2(2)
  ) u_dut_a (
    .clk(clk), .sreset(sreset), .continuous(continuous_a), .start(start_a),
    .sdo(sdo_a), .cnv(cnv_a), .sck(sck_a), .busy(busy_a), .overrun(overrun_a),
    .overrun_clr(overrun_clr_a), .sample(if_a)
  );

  logic       continuous_b, start_b, overrun_clr_b;
  logic [0:0] sdo_b;
  logic       cnv_b, sck_b, busy_b, overrun_b;

  ad400x_multi_read_if #(.NUM_CH(1), .ADC_WIDTH(18)) if_b ();

  ad400x_multi_read #(
    .ADC_WIDTH(18), .NUM_CH(1), .CONV_CYCLES(10), .SCK_DIV(1),
    .SAMPLE_PERIOD(60), .AVG_LOG2(2)
  ) u_dut_b (
    .clk(clk), .sreset(sreset), .continuous(continuous_b), .start(start_b),
    .sdo(sdo_b), .cnv(cnv_b), .sck(sck_b), .busy(busy_b), .overrun(overrun_b),
    .overrun_clr(overrun_clr_b), .sample(if_b)
  );

  // ADC emulators: latch the value on CNV rise (MSB appears at once), advance on SCK fall.
  logic [15:0] val_a [4];
  logic [15:0] sr_a [4];
  always @(posedge cnv_a or negedge sck_a) begin
    for (int c = 0; c < 4; c++) sr_a[c] = cnv_a ? val_a[c] : {sr_a[c][14:0], 1'b0};
  end
  always_comb begin
    for (int c = 0; c < 4; c++) sdo_a[c] = sr_a[c][15];
  end

  logic [17:0] val_b, sr_b;
  always @(posedge cnv_b or negedge sck_b) sr_b = cnv_b ? val_b : {sr_b[16:0], 1'b0};
  assign sdo_b[0] = sr_b[17];

  int cyc = 0, sck_pulses_a = 0, cnv_hi_a = 0, sck_pulses_b = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge sck_a) sck_pulses_a <= sck_pulses_a + 1;
  always @(posedge sck_b) sck_pulses_b <= sck_pulses_b + 1;
  always @(negedge clk) if (cnv_a === 1'b1) cnv_hi_a <= cnv_hi_a + 1;

  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] ch0, ch1, ch2, ch3;
    logic [63:0] exp_data;
  } vec_t;
  vec_t vecs [3];

  task automatic load_a(input int i);
    val_a[0] = vecs[i].ch0;
    val_a[1] = vecs[i].ch1;
    val_a[2] = vecs[i].ch2;
    val_a[3] = vecs[i].ch3;
  endtask

  // Counts clk edges from the one that samples start (edge 1) until data_valid is seen.
  task automatic wait_dv_a(output int t, output logic [1:0] first);
    t = 0;
    first = 2'b00;
    do begin
      @(negedge clk);
      start_a = 1'b0;
      t++;
      if (t == 1) first = {cnv_a, busy_a};
    end while (!if_a.data_valid && t < 400);
  endtask

  task automatic wait_busy_a(input logic lvl, input string name);
    int t = 0;
    while (busy_a !== lvl && t < 400) begin
      @(negedge clk);
      t++;
    end
    check(name, 64'(busy_a), 64'(lvl));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, p_sck, p_cnv, ndv, tb;
    logic [1:0]  first;
    int          t_pub [3];
    logic [15:0] avg_in [4];

    vecs[0] = '{ch0: 16'hAAAA, ch1: 16'h00F0, ch2: 16'hFFFF, ch3: 16'h0001, exp_data: 64'h0001_FFFF_00F0_AAAA};
    vecs[1] = '{ch0: 16'h0000, ch1: 16'h8000, ch2: 16'h0001, ch3: 16'h1234, exp_data: 64'h1234_0001_8000_0000};
    vecs[2] = '{ch0: 16'h5555, ch1: 16'hC3A5, ch2: 16'h7FFF, ch3: 16'hFFFE, exp_data: 64'hFFFE_7FFF_C3A5_5555};

    sreset = 1'b1;
    continuous_a = 1'b0; start_a = 1'b0; overrun_clr_a = 1'b0; if_a.data_ready = 1'b0;
    continuous_b = 1'b0; start_b = 1'b0; overrun_clr_b = 1'b0; if_b.data_ready = 1'b1;
    val_b = '0;
    load_a(0);
    repeat (3) @(negedge clk);
    check("reset_ctrl", 64'({cnv_a, sck_a, busy_a, if_a.data_valid, overrun_a}), 64'h0);
    check("reset_data", if_a.data, 64'h0);
    sreset = 1'b0;
    @(negedge clk);

`ifdef ADC_AVG_EN
    avg_in[0] = 16'd100; avg_in[1] = 16'd101; avg_in[2] = 16'd102; avg_in[3] = 16'd104;
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 4; c++) val_a[c] = avg_in[s] + 16'(16 * c);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      wait_busy_a(1'b0, $sformatf("avg%0d_done", s));
      if (s < 3) check($sformatf("avg%0d_no_publish", s), 64'(if_a.data_valid), 64'h0);
    end
    check("avg_valid", 64'({if_a.data_valid, overrun_a}), 64'h2);
    check("avg_data", if_a.data, 64'h0095_0085_0075_0065);
`else
    // Single-shot vectors.
    for (int i = 0; i < 3; i++) begin
      load_a(i);
      p_sck = sck_pulses_a;
      p_cnv = cnv_hi_a;
      start_a = 1'b1;
      wait_dv_a(lat, first);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'd116);
      check($sformatf("v%0d_data", i), if_a.data, vecs[i].exp_data);
      check($sformatf("v%0d_cnv_busy_first", i), 64'(first), 64'h3);
      check($sformatf("v%0d_busy_ovr_after", i), 64'({busy_a, overrun_a}), 64'h0);
      check($sformatf("v%0d_sck_pulses", i), 64'(sck_pulses_a - p_sck), 64'd16);
      check($sformatf("v%0d_cnv_high", i), 64'(cnv_hi_a - p_cnv), 64'd50);
      if_a.data_ready = 1'b1;
      @(negedge clk);
      if_a.data_ready = 1'b0;
      check($sformatf("v%0d_consumed", i), 64'(if_a.data_valid), 64'h0);
    end

    // Continuous with the consumer always ready.
    if_a.data_ready = 1'b1;
    load_a(0);
    continuous_a = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_dv_a(lat, first);
      t_pub[k] = cyc;
      check($sformatf("cont%0d_data", k), if_a.data, vecs[k].exp_data);
      check($sformatf("cont%0d_overrun", k), 64'(overrun_a), 64'h0);
      if (k < 2) load_a(k + 1);
      else continuous_a = 1'b0;
    end
    check("cont_period_01", 64'(t_pub[1] - t_pub[0]), 64'd120);
    check("cont_period_12", 64'(t_pub[2] - t_pub[1]), 64'd120);
    ndv = 0;
    repeat (150) begin
      @(negedge clk);
      if (if_a.data_valid || cnv_a) ndv++;
    end
    check("cont_stopped", 64'(ndv), 64'h0);
    if_a.data_ready = 1'b0;

    // Continuous with the consumer stalled: overrun on the second sample, newest wins.
    load_a(1);
    continuous_a = 1'b1;
    wait_busy_a(1'b1, "ovr_s1_start");
    wait_busy_a(1'b0, "ovr_s1_done");
    check("ovr_s1_flags", 64'({if_a.data_valid, overrun_a}), 64'h2);
    load_a(2);
    wait_busy_a(1'b1, "ovr_s2_start");
    wait_busy_a(1'b0, "ovr_s2_done");
    check("ovr_s2_flag", 64'(overrun_a), 64'h1);
    check("ovr_s2_data", if_a.data, vecs[2].exp_data);
    load_a(0);
    wait_busy_a(1'b1, "ovr_s3_start");
    wait_busy_a(1'b0, "ovr_s3_done");
    continuous_a = 1'b0;
    check("ovr_s3_data", if_a.data, vecs[0].exp_data);
    overrun_clr_a = 1'b1;
    @(negedge clk);
    overrun_clr_a = 1'b0;
    check("ovr_cleared", 64'({if_a.data_valid, overrun_a}), 64'h2);
    if_a.data_ready = 1'b1;
    @(negedge clk);
    if_a.data_ready = 1'b0;
    check("ovr_consumed", 64'(if_a.data_valid), 64'h0);
    repeat (10) @(negedge clk);

    // Reset 20 clk into SHIFT aborts the sample; the next start is clean.
    load_a(1);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (70) @(negedge clk);
    check("rst_pre_busy_cnv", 64'({busy_a, cnv_a}), 64'h2);
    sreset = 1'b1;
    @(negedge clk);
    check("rst_abort_ctrl", 64'({cnv_a, sck_a, busy_a, if_a.data_valid, overrun_a}), 64'h0);
    check("rst_abort_data", if_a.data, 64'h0);
    sreset = 1'b0;
    @(negedge clk);
    load_a(2);
    p_sck = sck_pulses_a;
    start_a = 1'b1;
    wait_dv_a(lat, first);
    check("rst_next_latency", 64'(lat), 64'd116);
    check("rst_next_data", if_a.data, vecs[2].exp_data);
    check("rst_next_sck_pulses", 64'(sck_pulses_a - p_sck), 64'd16);
    if_a.data_ready = 1'b1;
    @(negedge clk);
    if_a.data_ready = 1'b0;

    // 18-bit single-lane converter with the fastest SCK.
    val_b = 18'h2ABCD;
    p_sck = sck_pulses_b;
    start_b = 1'b1;
    tb = 0;
    do begin
      @(negedge clk);
      start_b = 1'b0;
      tb++;
    end while (!if_b.data_valid && tb < 200);
    check("w18_latency", 64'(tb), 64'd48);
    check("w18_data", 64'(if_b.data), 64'h2ABCD);
    check("w18_sck_pulses", 64'(sck_pulses_b - p_sck), 64'd18);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
